uart_rx_deserializer: RTL
=========================

# uart_rx_deserializer

RTL UART receive front-end that sits directly upstream of the receive-side packet layer. It recovers frames from the serial `rxIn` line using 16x or 13x oversampling and checks parity and stop bits. Each received character goes into a one-entry output buffer with a valid/ready handshake. Frame format comes from the shared UART configuration fields: baud rate, oversampling, data width, parity enable/type and stop bits.

## Interface
- `DATA_WIDTH`, 8: maximum character width; output data bus width.
- `CLK_FREQ_HZ`, 1_843_200: `clk` frequency, used to derive the oversample-tick divisors.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rxIn`  in  1  serial line, idle high, asynchronous to `clk`.
- `uartBaudRate`  in  32  BAUD_RATE_E value (4800/9600/19200).
- `uartOverSamplingMethod`  in  5  OVER_SAMPLING_E value (16/13).
- `uartDataType`  in  4  DATA_TYPE_E value (5..8 data bits).
- `uartParityEnable`  in  1  1 = parity bit present.
- `uartParityType`  in  1  PARITY_TYPE_E: 0 even, 1 odd.
- `uartStopBits`  in  2  STOP_BIT_E: 1 or 2.
- `rxData`  out  DATA_WIDTH  received character, LSB-aligned, unused upper bits 0.
- `rxValid`  out  1  `rxData`/error flags valid.
- `rxReady`  in  1  consumer accepts the buffered character.
- `rxParityError`  out  1  parity mismatch on the buffered character.
- `rxFramingError`  out  1  a stop bit was sampled low on the buffered character.
- `rxOverrun`  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- `rxIn` passes through a 2-flop synchronizer; both flops reset to 1.
- The tick generator produces a 1-cycle `tick` every DIV clocks. DIV = round(CLK_FREQ_HZ / (baud × oversampling)).
  - Unsupported baud values select the 9600 divisor. Any oversampling value other than 13 selects 16.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: on a tick with the synchronized line low, latch all config inputs and go to START with the tick count cleared. Config changes mid-frame are ignored.
- START: wait OS/2 ticks (8 or 6), then resample the line.
  - Low: clear the tick count and go to DATA.
  - High: glitch; return to IDLE with no output.
- DATA: sample every OS ticks, LSB first, for `uartDataType` bits.
  - Next state is PARITY if parity is enabled, else STOP1.
- PARITY: sample the parity bit.
  - Error if the count of ones in data+parity is odd under even parity, or even under odd parity.
- STOP1 and STOP2: sample at mid-bit; a low sample sets the framing error. STOP2 is entered only for TWO_BIT.
- Frame completion at the final stop sample:
  - If the buffer is empty, or `rxValid && rxReady` in the same cycle, load data and flags.
  - Otherwise pulse `rxOverrun`, drop the new frame and keep the old one.
- FSM returns to IDLE at the final stop sample, i.e. mid-stop-bit, ready for the next start edge.

## Timing
- Reset: FSM in IDLE, counters 0; `rxData`, `rxValid`, `rxParityError`, `rxFramingError` and `rxOverrun` are all 0.
- Reset takes effect immediately (asynchronous) at any point, including mid-frame; the partial frame is discarded.
- `rxValid` rises one clock after the final stop-bit sample cycle.
- `rxValid` and the data/flags are held stable until the rising edge where `rxValid && rxReady`; `rxValid` then drops the next cycle unless reloaded.
- Input-to-sample latency is 2 clocks (synchronizer), plus up to 1 tick of start-detection uncertainty.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN`:
  - Defined: each data, parity and stop bit is the majority of three samples taken at ticks center−1, center and center+1. The start re-check uses the same vote.
  - Undefined: one sample at the center tick.
- Frame timing and outputs are otherwise identical with or without the macro.

## Structure
- The shared UART package holds:
  - existing BAUD_RATE_E, OVER_SAMPLING_E, STOP_BIT_E, DATA_TYPE_E and PARITY_TYPE_E;
  - a new receiver FSM state enum;
  - a constant function returning DIV for a given clock frequency, baud and oversampling.
- Sub-module `uart_rx_tick_gen`: divisor selection mux plus free-running tick counter, with `tick` output.

## Test plan
- 9600 baud, 16x, 8 bits, no parity, 1 stop; send 0xA5 → `rxData`=0xA5, `rxValid`=1, no errors; `rxValid` holds until `rxReady`.
- 19200 baud, 13x, 7 bits, even parity, 2 stops; send 0x55 with a wrong parity bit → `rxData`=0x55, `rxParityError`=1.
- 4800 baud, 5 bits, stop bit driven low; send 0x1F → `rxData`=0x1F, `rxFramingError`=1.
- Low pulse of half a bit on an idle line → no `rxValid`, FSM back in IDLE.
- Two back-to-back frames 0x11 then 0x22 with `rxReady`=0 → `rxData` stays 0x11, `rxOverrun` pulses once. Repeat with `rxReady`=1 at the second completion → 0x22 loads, no overrun.
- Assert `reset` mid-DATA, release, send 0x3C → only 0x3C is delivered, with no residual from the partial frame.

Source files
------------

// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART types: frame-format enums, receiver FSM states and
// the oversample divisor helper used by the receive front-end.
package uart_rx_deserializer_pkg;

    typedef enum logic [31:0] {
        BAUD_4800  = 32'd4800,
        BAUD_9600  = 32'd9600,
        BAUD_19200 = 32'd19200
    } BAUD_RATE_E;

    typedef enum logic [4:0] {
        OS_13 = 5'd13,
        OS_16 = 5'd16
    } OVER_SAMPLING_E;

    typedef enum logic [1:0] {
        ONE_BIT = 2'd1,
        TWO_BIT = 2'd2
    } STOP_BIT_E;

    typedef enum logic [3:0] {
        DATA_5 = 4'd5,
        DATA_6 = 4'd6,
        DATA_7 = 4'd7,
        DATA_8 = 4'd8
    } DATA_TYPE_E;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } PARITY_TYPE_E;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2
    } rx_state_e;

    localparam int unsigned DIV_W = 16;

    function automatic int unsigned uart_div(
        input int unsigned clk_hz,
        input int unsigned baud,
        input int unsigned os
    );
        int unsigned d;
        d = (clk_hz + (baud * os) / 2) / (baud * os);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_tick.sv
// Oversample tick generator: picks the divisor for the active baud and
// oversampling ratio, then pulses tick_o once every DIV clocks.
module uart_rx_tick_gen
    import uart_rx_deserializer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 1_843_200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] baud_i,
    input  logic [4:0]  os_i,
    output logic        tick_o
);

    localparam logic [DIV_W-1:0] D4800_16  = DIV_W'(uart_div(CLK_FREQ_HZ, 4800, 16));
    localparam logic [DIV_W-1:0] D4800_13  = DIV_W'(uart_div(CLK_FREQ_HZ, 4800, 13));
    localparam logic [DIV_W-1:0] D9600_16  = DIV_W'(uart_div(CLK_FREQ_HZ, 9600, 16));
    localparam logic [DIV_W-1:0] D9600_13  = DIV_W'(uart_div(CLK_FREQ_HZ, 9600, 13));
    localparam logic [DIV_W-1:0] D19200_16 = DIV_W'(uart_div(CLK_FREQ_HZ, 19200, 16));
    localparam logic [DIV_W-1:0] D19200_13 = DIV_W'(uart_div(CLK_FREQ_HZ, 19200, 13));

    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             os13;

    always_comb begin
        os13 = (os_i == OS_13);
        case (baud_i)
            BAUD_4800:  div_m1 = (os13 ? D4800_13 : D4800_16) - 1'b1;
            BAUD_19200: div_m1 = (os13 ? D19200_13 : D19200_16) - 1'b1;
            default:    div_m1 = (os13 ? D9600_13 : D9600_16) - 1'b1;
        endcase
        // >= keeps the counter bounded when the divisor shrinks mid-count
        tick_o = (cnt_q >= div_m1);
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front-end with one-entry output buffer.
// Optional UART_RX_MAJORITY_VOTE_EN: 3-sample majority vote per bit.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CLK_FREQ_HZ = 1_843_200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxIn,
    input  logic [31:0]           uartBaudRate,
    input  logic [4:0]            uartOverSamplingMethod,
    input  logic [3:0]            uartDataType,
    input  logic                  uartParityEnable,
    input  logic                  uartParityType,
    input  logic [1:0]            uartStopBits,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic                  rxParityError,
    output logic                  rxFramingError,
    output logic                  rxOverrun
);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [4:0] LAG = 5'd1;
`else
    localparam logic [4:0] LAG = 5'd0;
`endif

    rx_state_e             state_q, state_d;
    logic [1:0]            sync_q;
    logic [4:0]            tcnt_q, tcnt_d;
    logic [3:0]            bitcnt_q, bitcnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [31:0]           cbaud_q, cbaud_d;
    logic [4:0]            cos_q, cos_d;
    logic [3:0]            cbits_q, cbits_d;
    logic                  cpen_q, cpen_d, cptype_q, cptype_d, cstop2_q, cstop2_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d, operr_q, operr_d;
    logic                  oferr_q, oferr_d, ovr_q, ovr_d;
    logic                  rx_s, bit_s, tick, samp, done, idle;
    logic [4:0]            target;

    assign rx_s = sync_q[1];
    assign idle = (state_q == RX_IDLE);

    uart_rx_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .baud_i (idle ? uartBaudRate : cbaud_q),
        .os_i   (idle ? uartOverSamplingMethod : cos_q),
        .tick_o (tick)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist_q[0] is the previous tick's sample, hist_q[1] the one before
    logic [1:0] hist_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    hist_q <= 2'b11;
        else if (tick) hist_q <= {hist_q[0], rx_s};
    end
    assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign bit_s = rx_s;
`endif

    assign target = (state_q == RX_START) ? {1'b0, cos_q[4:1]} : cos_q;
    assign samp   = tick && ((tcnt_q + 5'd1) == (target + LAG));

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        cbaud_d  = cbaud_q;
        cos_d    = cos_q;
        cbits_d  = cbits_q;
        cpen_d   = cpen_q;
        cptype_d = cptype_q;
        cstop2_d = cstop2_q;
        data_d   = data_q;
        valid_d  = valid_q;
        operr_d  = operr_q;
        oferr_d  = oferr_q;
        ovr_d    = 1'b0;
        done     = 1'b0;
        if (valid_q && rxReady) valid_d = 1'b0;
        if (!idle && tick) tcnt_d = samp ? LAG : tcnt_q + 5'd1;
        unique case (state_q)
            RX_IDLE: if (tick && !rx_s) begin
                state_d  = RX_START;
                tcnt_d   = '0;
                bitcnt_d = '0;
                shift_d  = '0;
                par_d    = 1'b0;
                perr_d   = 1'b0;
                ferr_d   = 1'b0;
                cbaud_d  = uartBaudRate;
                cos_d    = (uartOverSamplingMethod == OS_13) ? 5'd13 : 5'd16;
                cbits_d  = (uartDataType == 4'd0 || uartDataType > 4'(DATA_WIDTH))
                           ? 4'(DATA_WIDTH) : uartDataType;
                cpen_d   = uartParityEnable;
                cptype_d = uartParityType;
                cstop2_d = (uartStopBits == TWO_BIT);
            end
            RX_START: if (samp) state_d = bit_s ? RX_IDLE : RX_DATA;
            RX_DATA: if (samp) begin
                for (int i = 0; i < DATA_WIDTH; i++)
                    if (bitcnt_q == 4'(i)) shift_d[i] = bit_s;
                par_d = par_q ^ bit_s;
                if (bitcnt_q == cbits_q - 4'd1) begin
                    bitcnt_d = '0;
                    state_d  = cpen_q ? RX_PARITY : RX_STOP1;
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
            RX_PARITY: if (samp) begin
                perr_d  = ((par_q ^ bit_s) != cptype_q);
                state_d = RX_STOP1;
            end
            RX_STOP1: if (samp) begin
                ferr_d  = ferr_q | ~bit_s;
                state_d = cstop2_q ? RX_STOP2 : RX_IDLE;
                done    = !cstop2_q;
            end
            RX_STOP2: if (samp) begin
                ferr_d  = ferr_q | ~bit_s;
                state_d = RX_IDLE;
                done    = 1'b1;
            end
            default: state_d = RX_IDLE;
        endcase
        if (done) begin
            if (!valid_q || rxReady) begin
                data_d  = shift_d;
                valid_d = 1'b1;
                operr_d = perr_d;
                oferr_d = ferr_d;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= 2'b11;
            state_q  <= RX_IDLE;
            tcnt_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            cbaud_q  <= BAUD_9600;
            cos_q    <= 5'd16;
            cbits_q  <= 4'(DATA_WIDTH);
            cpen_q   <= 1'b0;
            cptype_q <= 1'b0;
            cstop2_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            operr_q  <= 1'b0;
            oferr_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], rxIn};
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            cbaud_q  <= cbaud_d;
            cos_q    <= cos_d;
            cbits_q  <= cbits_d;
            cpen_q   <= cpen_d;
            cptype_q <= cptype_d;
            cstop2_q <= cstop2_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            operr_q  <= operr_d;
            oferr_q  <= oferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rxData         = data_q;
    assign rxValid        = valid_q;
    assign rxParityError  = operr_q;
    assign rxFramingError = oferr_q;
    assign rxOverrun      = ovr_q;

endmodule
